// File: rtl/classificador_pkg.sv
// classificador_pkg: shared dimensions, FSM states and latency of the digit classifier.
package classificador_pkg;
    localparam int N_DIGITOS = 10;
    localparam int N_LINHAS  = 11;
    localparam int N_COLS    = 11;
    localparam int W_PIX     = 8;
    localparam int W_SCORE   = 16;
    localparam int W_SOMA    = W_PIX + 4;
    localparam int LAT_CLASS = N_DIGITOS * (N_LINHAS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACUM,
        COMPARA,
        FIM
    } estado_t;
endpackage

// File: rtl/classificador_digito_soma_linha.sv
// soma_linha: combinational balanced adder tree summing one 11-pixel difference row.
module soma_linha
    import classificador_pkg::*;
(
    input  logic [N_COLS*W_PIX-1:0] linha,
    output logic [W_SOMA-1:0]       soma
);
    logic [W_PIX:0]   par [5];
    logic [W_PIX+1:0] quad [3];
    logic [W_PIX+2:0] oito;

    for (genvar i = 0; i < 5; i++) begin : g_par
        assign par[i] = {1'b0, linha[2*i*W_PIX +: W_PIX]} + {1'b0, linha[(2*i+1)*W_PIX +: W_PIX]};
    end

    // The odd eleventh pixel joins at the second level to keep the tree depth at four.
    assign quad[0] = {1'b0, par[0]} + {1'b0, par[1]};
    assign quad[1] = {1'b0, par[2]} + {1'b0, par[3]};
    assign quad[2] = {1'b0, par[4]} + {2'b0, linha[10*W_PIX +: W_PIX]};
    assign oito    = {1'b0, quad[0]} + {1'b0, quad[1]};
    assign soma    = {1'b0, oito} + {2'b0, quad[2]};
endmodule

// File: rtl/classificador_digito.sv
// classificador_digito: scans ten 11x11 difference maps row by row and reports
// the digit with the smallest total difference, its score and a confidence flag.
module classificador_digito
    import classificador_pkg::*;
(
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic                    iStart,
    input  logic [W_SCORE-1:0]      iLimiar,
    output logic [3:0]              oDigitSel,
    output logic [3:0]              oLinhaSel,
    input  logic [N_COLS*W_PIX-1:0] iLinhaDiff,
    output logic                    oBusy,
    output logic                    oDone,
    output logic [3:0]              oDigito,
    output logic [W_SCORE-1:0]      oScore,
    output logic                    oValido
);
    estado_t              estado_q, estado_d;
    logic [3:0]           dig_q, dig_d, lin_q, lin_d;
    logic [3:0]           bdig_q, bdig_d, digito_q, digito_d;
    logic [W_SCORE-1:0]   acc_q, acc_d, best_q, best_d, score_q, score_d;
    logic                 busy_q, busy_d, done_q, done_d, valido_q, valido_d;
    logic [W_SOMA-1:0]    soma;
    logic [W_SCORE:0]     acc_soma;
    logic [W_SCORE-1:0]   acc_sat, best_n;
    logic [3:0]           bdig_n;
    logic                 melhor;

    soma_linha u_soma (
        .linha (iLinhaDiff),
        .soma  (soma)
    );

    // Saturate rather than wrap when a narrowed W_SCORE cannot hold the full total.
    assign acc_soma = {1'b0, acc_q} + (W_SCORE+1)'(soma);
    assign acc_sat  = acc_soma[W_SCORE] ? '1 : acc_soma[W_SCORE-1:0];
    assign melhor   = acc_q < best_q;
    assign best_n   = melhor ? acc_q : best_q;
    assign bdig_n   = melhor ? dig_q : bdig_q;

    always_comb begin
        estado_d = estado_q;
        dig_d    = dig_q;
        lin_d    = lin_q;
        acc_d    = acc_q;
        best_d   = best_q;
        bdig_d   = bdig_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        digito_d = digito_q;
        score_d  = score_q;
        valido_d = valido_q;
        unique case (estado_q)
            IDLE: if (iStart) begin
                estado_d = ACUM;
                dig_d    = '0;
                lin_d    = '0;
                acc_d    = '0;
                best_d   = '1;
                busy_d   = 1'b1;
            end
            ACUM: begin
                acc_d    = acc_sat;
                lin_d    = (lin_q < 4'(N_LINHAS-1)) ? lin_q + 4'd1 : lin_q;
                estado_d = (lin_q < 4'(N_LINHAS-1)) ? ACUM : COMPARA;
            end
            COMPARA: begin
                best_d = best_n;
                bdig_d = bdig_n;
                acc_d  = '0;
                lin_d  = '0;
                if (dig_q == 4'(N_DIGITOS-1)) begin
                    estado_d = FIM;
                    digito_d = bdig_n;
                    score_d  = best_n;
                    valido_d = best_n < iLimiar;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    estado_d = ACUM;
                    dig_d    = dig_q + 4'd1;
                end
            end
            FIM: begin
                estado_d = IDLE;
                dig_d    = '0;
                lin_d    = '0;
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            estado_q <= IDLE;
            dig_q    <= '0;
            lin_q    <= '0;
            acc_q    <= '0;
            best_q   <= '1;
            bdig_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digito_q <= '0;
            score_q  <= '0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            dig_q    <= dig_d;
            lin_q    <= lin_d;
            acc_q    <= acc_d;
            best_q   <= best_d;
            bdig_q   <= bdig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digito_q <= digito_d;
            score_q  <= score_d;
            valido_q <= valido_d;
        end
    end

    assign oDigitSel = dig_q;
    assign oLinhaSel = lin_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oDigito   = digito_q;
    assign oScore    = score_q;
    assign oValido   = valido_q;
endmodule

// File: tb/tb_classificador_digito.sv
// tb_classificador_digito: directed vectors on per-digit constant maps with an
// optional bump at row 10 / column 10, checked against hand-computed totals.
module tb_classificador_digito;
    logic         iCLK = 1'b0;
    logic         iRST_N = 1'b0;
    logic         iStart = 1'b0;
    logic [15:0]  iLimiar = '0;
    logic [3:0]   oDigitSel, oLinhaSel, oDigito;
    logic [87:0]  iLinhaDiff;
    logic         oBusy, oDone, oValido;
    logic [15:0]  oScore;

    logic [7:0]   val   [16];
    logic [7:0]   extra [16];
    int           total = 0;
    int           bad = 0;
    int           n;
    bit           done_seen;

    classificador_digito dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iStart     (iStart),
        .iLimiar    (iLimiar),
        .oDigitSel  (oDigitSel),
        .oLinhaSel  (oLinhaSel),
        .iLinhaDiff (iLinhaDiff),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oDigito    (oDigito),
        .oScore     (oScore),
        .oValido    (oValido)
    );

    always #5 iCLK = ~iCLK;

    always_comb begin
        iLinhaDiff = '0;
        for (int c = 0; c < 11; c++)
            iLinhaDiff[c*8 +: 8] = (oDigitSel < 4'd10)
                ? val[oDigitSel] + ((oLinhaSel == 4'd10 && c == 10) ? extra[oDigitSel] : 8'd0)
                : 8'd0;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_maps(input int base, input int step);
        for (int d = 0; d < 16; d++) begin
            val[d]   = 8'(base - step * d);
            extra[d] = 8'd0;
        end
    endtask

    task automatic run(input bit pulse);
        @(negedge iCLK) iStart = 1'b1;
        @(negedge iCLK) iStart = 1'b0;
        chk("busy_on_start", oBusy, 1);
        n = 0;
        while (!oDone && n < 200) begin
            iStart = pulse && (n == 50);
            @(negedge iCLK);
            n++;
        end
        iStart = 1'b0;
        chk("latency", n, 120);
        chk("busy_at_done", oBusy, 0);
        @(negedge iCLK);
        chk("done_pulse_ends", oDone, 0);
        chk("sel_back_to_zero", {oDigitSel, oLinhaSel}, 0);
    endtask

    task automatic expect_result(input string tag, input int dig, input int sc, input int vld);
        chk({tag, "_digito"}, oDigito, dig);
        chk({tag, "_score"}, oScore, sc);
        chk({tag, "_valido"}, oValido, vld);
    endtask

    initial begin
        set_maps(0, 0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        done_seen = 1'b0;
        repeat (5) begin
            @(negedge iCLK);
            done_seen |= oDone;
        end
        chk("idle_no_done", done_seen, 0);
        chk("idle_busy", oBusy, 0);
        chk("idle_sel", {oDigitSel, oLinhaSel}, 0);
        expect_result("reset", 0, 0, 0);

        // Digit 3 all ones, everything else zero: digit 0 wins with score 0.
        val[3] = 8'd1;
        iLimiar = 16'd1;
        run(1'b0);
        expect_result("zeros", 0, 0, 1);

        // Decreasing constants: digit 9 at 110 per pixel wins with 13310.
        set_maps(200, 10);
        iLimiar = 16'd13310;
        run(1'b0);
        expect_result("const_lim_eq", 9, 13310, 0);
        iLimiar = 16'd13311;
        run(1'b0);
        expect_result("const_lim_above", 9, 13310, 1);
        repeat (4) @(negedge iCLK);
        expect_result("hold", 9, 13310, 1);

        // Tie at 500 between digits 4 and 6: the lower digit is kept.
        set_maps(5, 0);
        val[4] = 8'd4;  extra[4] = 8'd16;
        val[6] = 8'd4;  extra[6] = 8'd16;
        iLimiar = 16'd500;
        run(1'b0);
        expect_result("tie", 4, 500, 0);

        // Digit 2 at 99 would win unless the bump in its last row/column is summed.
        set_maps(100, 0);
        val[2] = 8'd99;  extra[2] = 8'd150;
        iLimiar = 16'd12101;
        run(1'b0);
        expect_result("last_pixel", 0, 12100, 1);

        // Maximum total: all pixels 255.
        set_maps(255, 0);
        iLimiar = 16'hFFFF;
        run(1'b0);
        expect_result("max", 0, 30855, 1);

        // Reset in the middle of a run, then a clean restart with a stray iStart.
        set_maps(50, 0);
        val[7] = 8'd20;
        iLimiar = 16'd3000;
        @(negedge iCLK) iStart = 1'b1;
        @(negedge iCLK) iStart = 1'b0;
        repeat (59) @(negedge iCLK);
        iRST_N = 1'b0;
        @(negedge iCLK) iRST_N = 1'b1;
        chk("abort_busy", oBusy, 0);
        chk("abort_sel", {oDigitSel, oLinhaSel}, 0);
        expect_result("abort", 0, 0, 0);
        done_seen = 1'b0;
        repeat (80) begin
            @(negedge iCLK);
            done_seen |= oDone;
        end
        chk("abort_no_done", done_seen, 0);
        run(1'b1);
        expect_result("restart", 7, 2420, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
